x25519_mult_arbiter: RTL

Shares one X25519_Mult field multiplier (264-bit operands, one operation in flight, `en` pulse in, `out_valid` pulse out) between NUM_PORTS requesters, such as ladder-step, inversion and point-encoding units. The block arbitrates requests, registers the winner's operands onto the multiplier, tracks the owner, and routes the result back with a per-port completion pulse. It sits between the requesters and the single multiplier instance in the X25519 core.

---
 rtl/x25519_pkg.sv | 12 +
 rtl/x25519_mult_arbiter_if.sv | 30 +++
 rtl/x25519_arb_picker.sv | 30 +++
 rtl/x25519_mult_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/x25519_pkg.sv
// Shared constants and types for the X25519 multiplier arbiter.
package x25519_pkg;

    localparam int unsigned X25519_WIDTH = 264;

    typedef enum logic [1:0] {DRAIN, IDLE, BUSY} x25519_arb_state_t;

    // Field prime 2^255-19, zero-extended to the operand width
    localparam logic [X25519_WIDTH-1:0] P25519 =
        (X25519_WIDTH'(1) << 255) - X25519_WIDTH'(19);

endpackage

// File: rtl/x25519_mult_arbiter_if.sv
// Requester and multiplier signals of the arbiter; slave = arbiter side, master = environment.
interface x25519_mult_arbiter_if
    import x25519_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = X25519_WIDTH
);
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS*WIDTH-1:0] req_a;
    logic [NUM_PORTS*WIDTH-1:0] req_b;
    logic [NUM_PORTS-1:0]       grant;
    logic [NUM_PORTS-1:0]       done;
    logic [WIDTH-1:0]           out;
    logic                       busy;
    logic                       mult_en;
    logic [WIDTH-1:0]           mult_a;
    logic [WIDTH-1:0]           mult_b;
    logic                       mult_out_valid;
    logic [WIDTH-1:0]           mult_out;

    modport slave (
        input  req, req_a, req_b, mult_out_valid, mult_out,
        output grant, done, out, busy, mult_en, mult_a, mult_b
    );

    modport master (
        output req, req_a, req_b, mult_out_valid, mult_out,
        input  grant, done, out, busy, mult_en, mult_a, mult_b
    );
endinterface

// File: rtl/x25519_arb_picker.sv
// Combinational one-hot selector: first set request at or after `start`, wrapping around.
module x25519_arb_picker #(
    parameter int unsigned NUM_PORTS = 4,
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    logic [31:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pos = (32'(start) + 32'(k)) % NUM_PORTS;
            if (!any && req[pos[IDX_W-1:0]]) begin
                any                     = 1'b1;
                onehot[pos[IDX_W-1:0]]  = 1'b1;
                idx                     = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/x25519_mult_arbiter.sv
// Shares one X25519 field multiplier between NUM_PORTS requesters.
// Define X25519_MULT_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module x25519_mult_arbiter
    import x25519_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned WIDTH        = X25519_WIDTH,
    parameter int unsigned DRAIN_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    x25519_mult_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    x25519_arb_state_t    state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic                 mult_en_q, mult_en_d;
    logic [WIDTH-1:0]     mult_a_q, mult_a_d;
    logic [WIDTH-1:0]     mult_b_q, mult_b_d;
    logic [WIDTH-1:0]     out_q, out_d;

    logic [IDX_W-1:0]     start;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 take;

`ifdef X25519_MULT_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : IDX_W'(pick_idx + 1'b1);
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    x25519_arb_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req    (bus.req),
        .start  (start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign take = (state_q == IDLE) && pick_any;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (bus.mult_out_valid) state_d = IDLE;
            default: state_d = DRAIN;
        endcase
    end

    // Registered outputs: next values
    always_comb begin
        grant_d   = '0;
        done_d    = '0;
        mult_en_d = 1'b0;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        out_d     = out_q;
        owner_d   = owner_q;
        if (take) begin
            grant_d   = pick_onehot;
            mult_en_d = 1'b1;
            mult_a_d  = bus.req_a[int'(pick_idx) * WIDTH +: WIDTH];
            mult_b_d  = bus.req_b[int'(pick_idx) * WIDTH +: WIDTH];
            owner_d   = pick_idx;
        end
        if (state_q == BUSY && bus.mult_out_valid) begin
            done_d[owner_q] = 1'b1;
            out_d           = bus.mult_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            done_q    <= '0;
            mult_en_q <= 1'b0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            out_q     <= '0;
            owner_q   <= '0;
        end else begin
            grant_q   <= grant_d;
            done_q    <= done_d;
            mult_en_q <= mult_en_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            out_q     <= out_d;
            owner_q   <= owner_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.mult_en = mult_en_q;
    assign bus.mult_a  = mult_a_q;
    assign bus.mult_b  = mult_b_q;
    assign bus.out     = out_q;
    assign bus.busy    = (state_q != IDLE);

endmodule
